// File: rtl/adf4158_pkg.sv
// Shared ADF4158 sweep geometry and ramp-sync state encoding.
// The config controller imports the same defaults so both sides agree on sweep timing.
package adf4158_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_CFG  = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } ramp_state_e;

  // MUXOUT select that routes digital lock detect to the pin
  localparam logic [3:0] MUXOUT_DLD = 4'b0110;

  localparam int unsigned DEF_LOCK_CYCLES = 1024;
  localparam int unsigned DEF_STEP_CLKS   = 20;
  localparam int unsigned DEF_RAMP_STEPS  = 2000;
  localparam int unsigned DEF_STEP_W      = 11;
  localparam int unsigned DEF_FRAME_W     = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/fmcw_ramp_sync.sv
// Qualifies ADF4158 digital lock detect and generates the nominal sweep timebase
// (sweep strobe, step index, frame count); halts and flags on loss of lock.
module fmcw_ramp_sync
  import adf4158_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned STEP_CLKS   = DEF_STEP_CLKS,
  parameter int unsigned RAMP_STEPS  = DEF_RAMP_STEPS,
  parameter int unsigned STEP_W      = DEF_STEP_W,
  parameter int unsigned FRAME_W     = DEF_FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               config_done_i,
  input  logic               muxout_i,
  input  logic               clr_err_i,
  output logic               locked_o,
  output logic               ramp_start_o,
  output logic               ramp_active_o,
  output logic [STEP_W-1:0]  step_idx_o,
  output logic [FRAME_W-1:0] frame_ctr_o,
  output logic               lock_lost_o
);

  localparam int unsigned LOCK_W    = cnt_w(LOCK_CYCLES);
  localparam int unsigned STEPCLK_W = cnt_w(STEP_CLKS);

  localparam logic [LOCK_W-1:0]    LOCK_LAST    = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [STEPCLK_W-1:0] STEPCLK_LAST = STEPCLK_W'(STEP_CLKS - 1);
  localparam logic [STEP_W-1:0]    STEP_LAST    = STEP_W'(RAMP_STEPS - 1);

  logic mx_s;

  ramp_state_e          state_q,       state_d;
  logic [LOCK_W-1:0]    lock_ctr_q,    lock_ctr_d;
  logic [STEPCLK_W-1:0] step_clk_q,    step_clk_d;
  logic [STEP_W-1:0]    step_idx_q,    step_idx_d;
  logic [FRAME_W-1:0]   frame_ctr_q,   frame_ctr_d;
  logic                 locked_q,      locked_d;
  logic                 ramp_start_q,  ramp_start_d;
  logic                 ramp_active_q, ramp_active_d;
  logic                 lock_lost_q,   lock_lost_d;
  logic                 run_ok;

  sync_2ff u_sync_muxout (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (muxout_i),
    .q_o   (mx_s)
  );

  assign run_ok = en_i & config_done_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_WAIT_CFG;
      lock_ctr_q    <= '0;
      step_clk_q    <= '0;
      step_idx_q    <= '0;
      frame_ctr_q   <= '0;
      locked_q      <= 1'b0;
      ramp_start_q  <= 1'b0;
      ramp_active_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_ctr_q    <= lock_ctr_d;
      step_clk_q    <= step_clk_d;
      step_idx_q    <= step_idx_d;
      frame_ctr_q   <= frame_ctr_d;
      locked_q      <= locked_d;
      ramp_start_q  <= ramp_start_d;
      ramp_active_q <= ramp_active_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_clk_d    = step_clk_q;
    step_idx_d    = step_idx_q;
    frame_ctr_d   = frame_ctr_q;
    locked_d      = locked_q;
    ramp_start_d  = 1'b0;
    ramp_active_d = ramp_active_q;
    lock_lost_d   = lock_lost_q;

    // Lock qualifier: run of consecutive synchronised-high cycles, saturating
    if (!mx_s) begin
      lock_ctr_d = '0;
    end else if (lock_ctr_q == LOCK_LAST) begin
      lock_ctr_d = lock_ctr_q;
    end else begin
      lock_ctr_d = lock_ctr_q + LOCK_W'(1);
    end

    if (!run_ok) begin
      state_d       = ST_WAIT_CFG;
      locked_d      = 1'b0;
      ramp_active_d = 1'b0;
      step_idx_d    = '0;
      step_clk_d    = '0;
    end else begin
      // A loss detected in RUN below overrides this clear
      if (clr_err_i) begin
        lock_lost_d = 1'b0;
      end

      unique case (state_q)
        ST_WAIT_CFG: begin
          state_d    = ST_WAIT_LOCK;
          lock_ctr_d = '0;
        end

        ST_WAIT_LOCK: begin
          if (mx_s && (lock_ctr_q == LOCK_LAST)) begin
            state_d       = ST_RUN;
            locked_d      = 1'b1;
            ramp_start_d  = 1'b1;
            ramp_active_d = 1'b1;
            step_idx_d    = '0;
            step_clk_d    = '0;
          end
        end

        ST_RUN: begin
          if (!mx_s) begin
            state_d       = ST_FAULT;
            lock_lost_d   = 1'b1;
            locked_d      = 1'b0;
            ramp_active_d = 1'b0;
          end else if (step_clk_q == STEPCLK_LAST) begin
            step_clk_d = '0;
            if (step_idx_q == STEP_LAST) begin
              step_idx_d   = '0;
              frame_ctr_d  = frame_ctr_q + FRAME_W'(1);
              ramp_start_d = 1'b1;
            end else begin
              step_idx_d = step_idx_q + STEP_W'(1);
            end
          end else begin
            step_clk_d = step_clk_q + STEPCLK_W'(1);
          end
        end

        ST_FAULT: begin
          if (clr_err_i) begin
            state_d    = ST_WAIT_LOCK;
            lock_ctr_d = '0;
          end
        end

        default: begin
          state_d = ST_WAIT_CFG;
        end
      endcase
    end
  end

  assign locked_o      = locked_q;
  assign ramp_start_o  = ramp_start_q;
  assign ramp_active_o = ramp_active_q;
  assign step_idx_o    = step_idx_q;
  assign frame_ctr_o   = frame_ctr_q;
  assign lock_lost_o   = lock_lost_q;

endmodule

// File: tb/tb_fmcw_ramp_sync.sv
// Directed bench for fmcw_ramp_sync with a short sweep geometry.
module tb_fmcw_ramp_sync;

  localparam int unsigned LC = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned RS = 3;
  localparam int unsigned SW = 2;
  localparam int unsigned FW = 4;
  localparam int unsigned SWEEP = SC * RS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          config_done;
  logic          muxout;
  logic          clr_err;
  logic          locked;
  logic          ramp_start;
  logic          ramp_active;
  logic [SW-1:0] step_idx;
  logic [FW-1:0] frame_ctr;
  logic          lock_lost;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmcw_ramp_sync #(
    .LOCK_CYCLES (LC),
    .STEP_CLKS   (SC),
    .RAMP_STEPS  (RS),
    .STEP_W      (SW),
    .FRAME_W     (FW)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en),
    .config_done_i (config_done),
    .muxout_i      (muxout),
    .clr_err_i     (clr_err),
    .locked_o      (locked),
    .ramp_start_o  (ramp_start),
    .ramp_active_o (ramp_active),
    .step_idx_o    (step_idx),
    .frame_ctr_o   (frame_ctr),
    .lock_lost_o   (lock_lost)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic rs, input logic ra,
                         input logic [SW-1:0] si, input logic [FW-1:0] fc, input logic ll);
    chk({tag, ".locked"},      32'(locked),      32'(lk));
    chk({tag, ".ramp_start"},  32'(ramp_start),  32'(rs));
    chk({tag, ".ramp_active"}, 32'(ramp_active), 32'(ra));
    chk({tag, ".step_idx"},    32'(step_idx),    32'(si));
    chk({tag, ".frame_ctr"},   32'(frame_ctr),   32'(fc));
    chk({tag, ".lock_lost"},   32'(lock_lost),   32'(ll));
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b1;
    config_done = 1'b0;
    muxout      = 1'b1;
    clr_err     = 1'b0;

    tick(3);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(6);
    chk_all("no_cfg", 0, 0, 0, 0, 0, 0);

    // muxout low in WAIT_CFG, then rises together with config_done: 2 sync + 8 qualify
    muxout = 1'b0;
    tick(4);
    config_done = 1'b1;
    muxout      = 1'b1;
    tick(9);
    chk_all("qualify", 0, 0, 0, 0, 0, 0);
    tick(1);
    chk_all("lock_rise", 1, 1, 1, 0, 0, 0);

    // Continuous sweeps through frame_ctr wrap (cycle 0 = RUN entry)
    for (int c = 1; c <= 196; c++) begin
      tick(1);
      chk("sweep.step_idx",   32'(step_idx),   32'((c % SWEEP) / SC));
      chk("sweep.ramp_start", 32'(ramp_start), 32'((c % SWEEP) == 0));
      chk("sweep.frame_ctr",  32'(frame_ctr),  32'((c / SWEEP) % 16));
    end

    // One-cycle muxout dip at step_idx=1 -> fault two edges after sync
    muxout = 1'b0;
    tick(1);
    muxout = 1'b1;
    chk_all("dip_c197", 1, 0, 1, 1, 0, 0);
    tick(1);
    chk_all("dip_c198", 1, 0, 1, 1, 0, 0);
    tick(1);
    chk_all("fault", 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_all("fault_hold", 0, 0, 0, 1, 0, 1);
    end

    // Clear and relock after 8 qualifying cycles
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk_all("clr_err", 0, 0, 0, 1, 0, 0);
    tick(7);
    chk_all("relock_wait", 0, 0, 0, 1, 0, 0);
    tick(1);
    chk_all("relock", 1, 1, 1, 0, 0, 0);

    // Drop en mid-RUN at step_idx=1 of second sweep
    tick(17);
    chk_all("pre_en_drop", 1, 0, 1, 1, 1, 0);
    en = 1'b0;
    tick(1);
    chk_all("en_drop", 0, 0, 0, 0, 1, 0);
    tick(3);
    chk_all("en_low_hold", 0, 0, 0, 0, 1, 0);

    // Requalify with a one-cycle dip after a few high cycles
    en = 1'b1;
    tick(3);
    muxout = 1'b0;
    tick(1);
    muxout = 1'b1;
    tick(5);
    chk_all("dip_wl_p9", 0, 0, 0, 0, 1, 0);
    tick(4);
    chk_all("dip_wl_p13", 0, 0, 0, 0, 1, 0);
    tick(1);
    chk_all("dip_wl_lock", 1, 1, 1, 0, 1, 0);

    // Loss aligned with the wrap edge, clr_err on the same edge
    tick(9);
    chk_all("wrap_r9", 1, 0, 1, 2, 1, 0);
    muxout = 1'b0;
    tick(1);
    muxout = 1'b1;
    tick(1);
    chk_all("wrap_r11", 1, 0, 1, 2, 1, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk_all("wrap_fault", 0, 0, 0, 2, 1, 1);
    tick(12);
    chk_all("wrap_fault_hold", 0, 0, 0, 2, 1, 1);

    // Reset clears sticky flag and frame count
    rst_n = 1'b0;
    tick(1);
    chk_all("reset2", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
